// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Matrix keypad scanner: drives one active-low column at a time, reads the
// active-low rows through a two-flop synchroniser, debounces press and
// release, rejects multi-key (ghost) patterns and reports the key as
// col*ROWS + row with a one-cycle key_valid strobe and a key_held level.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat strobes while a
// key stays held, controlled by REPEAT_DELAY and REPEAT_PERIOD).
module keypad_scan_debounce #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
`endif
    localparam int CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    // The synchroniser adds two cycles between a column change and the
    // moment rs reflects it, so the scan sample point is pushed out by that
    // depth; otherwise a column would be judged on the previous drive.
    localparam int SYNC_STAGES = 2;
    localparam int SCAN_LAST   = SETTLE_CYCLES - 1 + SYNC_STAGES;
    localparam int SET_W       = $clog2(SCAN_LAST + 1);
    localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int COL_W       = $clog2(COLS);
    localparam int ROW_W       = $clog2(ROWS);

    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SCAN_LAST);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_SAT      = RPT_W'(RPT_MAX);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    // ------------------------------------------------------------------
    // Row synchroniser
    // ------------------------------------------------------------------
    logic [ROWS-1:0] sync1_q;
    logic [ROWS-1:0] rs_q;

    // Two-flop synchroniser; resets to "no key" since the rows are pulled up.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like real registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            rs_q    <= '1;
        end else begin
            sync1_q <= row_in;
            rs_q    <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Row pattern classification
    // ------------------------------------------------------------------
    logic             rs_none;
    logic             rs_single;
    logic [ROW_W-1:0] rs_row;

    // Classify rs as none / single / multi and locate the low row.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs_none   = (rs_q == '1);
        rs_single = ($countones(~rs_q) == 1);
        rs_row    = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!rs_q[i]) begin
                rs_row = ROW_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan / debounce FSM
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [COL_W-1:0]  col_q,       col_d;
    logic [ROW_W-1:0]  row_q,       row_d;
    logic [ROWS-1:0]   pat_q,       pat_d;
    logic [SET_W-1:0]  set_cnt_q,   set_cnt_d;
    logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic [DB_W-1:0]   db_inc;
    logic [COLS-1:0]   col_out_q,   col_out_d;
    logic [CODE_W-1:0] key_code_q,  key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q,  key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [RPT_W-1:0]  rpt_cnt_q,   rpt_cnt_d;
    logic [RPT_W-1:0]  rpt_inc;
    logic              rpt_first_q, rpt_first_d;
`endif

    // Next-state and next-output logic for the scan/debounce sequence.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pat_d       = pat_q;
        set_cnt_d   = set_cnt_q;
        db_cnt_d    = db_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        db_inc      = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_inc     = (rpt_cnt_q == RPT_SAT) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!rs_none) begin
                    state_d   = S_SCAN;
                    col_d     = '0;
                    set_cnt_d = '0;
                end
            end

            S_SCAN: begin
                if (set_cnt_q == SET_MAX) begin
                    if (rs_single) begin
                        row_d    = rs_row;
                        pat_d    = rs_q;
                        db_cnt_d = '0;
                        state_d  = S_PRESS_DB;
                    end else if (col_q == COL_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        col_d     = col_q + 1'b1;
                        set_cnt_d = '0;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end

            S_PRESS_DB: begin
                if (rs_q != pat_q) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_inc == DB_MAX) begin
                    state_d     = S_HELD;
                    db_cnt_d    = '0;
                    key_code_d  = CODE_W'(col_q) * CODE_W'(ROWS) + CODE_W'(row_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
`endif
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            S_HELD: begin
                if (rs_none) begin
                    state_d  = S_REL_DB;
                    db_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else if (!rpt_first_q) begin
                    if (rpt_inc == RPT_DELAY_C) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
                end else begin
                    if (rpt_inc == RPT_PERIOD_C) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
`endif
                end
            end

            S_REL_DB: begin
                if (!rs_none) begin
                    // Release bounce: back to held without a new event.
                    state_d  = S_HELD;
                    db_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
`endif
                end else if (db_inc == DB_MAX) begin
                    state_d    = S_IDLE;
                    db_cnt_d   = '0;
                    key_held_d = 1'b0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        col_out_d = (state_d == S_IDLE) ? '0 : ~(COLS'(1) << col_d);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pat_q       <= '1;
            set_cnt_q   <= '0;
            db_cnt_q    <= '0;
            col_out_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            set_cnt_q   <= set_cnt_d;
            db_cnt_q    <= db_cnt_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce: a combinational keypad model pulls a
// row low when a pressed key's column is driven low; a monitor records every
// key_valid strobe, and each scenario task compares against codes and
// timing windows derived from the key position and debounce settings.
module tb_keypad_scan_debounce;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SETTLE   = 2;
    localparam int DEBOUNCE = 8;
    localparam int CODE_W   = $clog2(ROWS * COLS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_DELAY  = 40;
    localparam int RPT_PERIOD = 10;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [ROWS-1:0]   row_in;
    logic [COLS-1:0]   col_out;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;

    logic [ROWS*COLS-1:0] key_mask = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int cyc = 0;
    int ev_code[$];
    int ev_cyc[$];
    bit ev_held[$];
    bit ev_held_prev[$];
    bit held_prev  = 1'b0;
    int n_col_idle = 0;
    int n_col_scan = 0;
    int n_col_bad  = 0;
    int n_held_low = 0;

    keypad_scan_debounce #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SETTLE_CYCLES   (SETTLE),
`ifdef KEYPAD_AUTOREPEAT_EN
        .REPEAT_DELAY    (RPT_DELAY),
        .REPEAT_PERIOD   (RPT_PERIOD),
`endif
        .DEBOUNCE_CYCLES (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_in = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (key_mask[c*ROWS + r] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            ev_code.push_back(int'(key_code));
            ev_cyc.push_back(cyc);
            ev_held.push_back(key_held);
            ev_held_prev.push_back(held_prev);
        end
        held_prev <= key_held;
        if (key_held !== 1'b1) n_held_low <= n_held_low + 1;
        if (col_out == '0) n_col_idle <= n_col_idle + 1;
        else if ($countones(~col_out) == 1) n_col_scan <= n_col_scan + 1;
        else n_col_bad <= n_col_bad + 1;
    end

    task automatic wait_event(input int base, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (ev_code.size() > base) got = 1'b1;
        end
    endtask

    task automatic wait_released(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget && lat < 0; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) lat = i;
        end
    endtask

    task automatic test_reset();
        key_mask = '0;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (col_out !== '0) $display("FAIL reset_col_out: got %b expected 0", col_out); else pass_cnt++;
        total_cnt++; if (key_code !== '0) $display("FAIL reset_key_code: got %0d expected 0", key_code); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else pass_cnt++;
        total_cnt++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b expected 0", key_held); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total_cnt++; if (col_out !== '0) $display("FAIL idle_col_out: got %b expected 0", col_out); else pass_cnt++;
        total_cnt++; if (ev_code.size() !== 0) $display("FAIL idle_no_event: got %0d events expected 0", ev_code.size()); else pass_cnt++;
    endtask

    // Clean press of col 2 / row 1, then release timing.
    task automatic test_clean_press();
        int base, lat, code;
        bit got;
        base = ev_code.size();
        @(negedge clk);
        key_mask[2*ROWS + 1] = 1'b1;
        wait_event(base, 200, got);
        total_cnt++; if (got !== 1'b1) $display("FAIL clean_press_seen: got %b expected 1", got); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++; if (ev_code.size() - base !== 1) $display("FAIL clean_press_count: got %0d expected 1", ev_code.size() - base); else pass_cnt++;
        code = got ? ev_code[base] : -1;
        total_cnt++; if (code !== 2*ROWS + 1) $display("FAIL clean_press_code: got %0d expected %0d", code, 2*ROWS + 1); else pass_cnt++;
        total_cnt++; if (got && ev_held[base] !== 1'b1) $display("FAIL held_with_valid: got 0 expected 1"); else pass_cnt++;
        total_cnt++; if (got && ev_held_prev[base] !== 1'b0) $display("FAIL held_rise_same_cycle: held before strobe got 1 expected 0"); else pass_cnt++;
        total_cnt++; if (key_held !== 1'b1) $display("FAIL clean_still_held: got %b expected 1", key_held); else pass_cnt++;
        key_mask = '0;
        wait_released(100, lat);
        // Debounce window plus two synchroniser stages and one state entry.
        total_cnt++; if (!(lat >= DEBOUNCE + 2 && lat <= DEBOUNCE + 4)) $display("FAIL release_latency: got %0d expected %0d..%0d", lat, DEBOUNCE + 2, DEBOUNCE + 4); else pass_cnt++;
        total_cnt++; if (int'(key_code) !== 2*ROWS + 1) $display("FAIL code_holds_after_release: got %0d expected %0d", key_code, 2*ROWS + 1); else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    // Press bounce: 3-cycle toggles for 30 cycles, then steady.
    task automatic test_bounce();
        int base, lat, code, idx;
        bit got;
        idx  = 3*ROWS + 1;
        base = ev_code.size();
        for (int k = 0; k < 10; k++) begin
            key_mask[idx] = ~key_mask[idx];
            repeat (3) @(negedge clk);
        end
        total_cnt++; if (ev_code.size() !== base) $display("FAIL bounce_no_valid: got %0d events expected 0", ev_code.size() - base); else pass_cnt++;
        key_mask[idx] = 1'b1;
        wait_event(base, 200, got);
        repeat (10) @(negedge clk);
        total_cnt++; if (ev_code.size() - base !== 1) $display("FAIL bounce_one_valid: got %0d expected 1", ev_code.size() - base); else pass_cnt++;
        code = got ? ev_code[base] : -1;
        total_cnt++; if (code !== idx) $display("FAIL bounce_code: got %0d expected %0d", code, idx); else pass_cnt++;
        key_mask = '0;
        wait_released(100, lat);
        total_cnt++; if (lat < 0) $display("FAIL bounce_release: got no release expected key_held low"); else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    // Two keys on column 0: no event, FSM keeps rescanning.
    task automatic test_ghost();
        int base, idle0, scan0, bad0;
        base  = ev_code.size();
        idle0 = n_col_idle;
        scan0 = n_col_scan;
        bad0  = n_col_bad;
        key_mask[0*ROWS + 0] = 1'b1;
        key_mask[0*ROWS + 3] = 1'b1;
        repeat (100) @(negedge clk);
        total_cnt++; if (ev_code.size() !== base) $display("FAIL ghost_no_valid: got %0d events expected 0", ev_code.size() - base); else pass_cnt++;
        total_cnt++; if (key_held !== 1'b0) $display("FAIL ghost_not_held: got %b expected 0", key_held); else pass_cnt++;
        total_cnt++; if (n_col_scan == scan0) $display("FAIL ghost_scans: got 0 scan cycles expected some"); else pass_cnt++;
        total_cnt++; if (n_col_idle == idle0) $display("FAIL ghost_returns_idle: got 0 idle cycles expected some"); else pass_cnt++;
        total_cnt++; if (n_col_bad !== bad0) $display("FAIL ghost_col_onehot: got %0d bad drives expected 0", n_col_bad - bad0); else pass_cnt++;
        key_mask = '0;
        repeat (20) @(negedge clk);
    endtask

    // Short release glitch while held must not drop key_held or re-strobe.
    task automatic test_release_glitch();
        int base, base2, low0, lat, code, idx;
        bit got;
        idx  = int'($urandom_range(COLS - 1)) * ROWS + int'($urandom_range(ROWS - 1));
        base = ev_code.size();
        key_mask[idx] = 1'b1;
        wait_event(base, 200, got);
        code = got ? ev_code[base] : -1;
        total_cnt++; if (code !== idx) $display("FAIL glitch_press_code: got %0d expected %0d", code, idx); else pass_cnt++;
        repeat (10) @(negedge clk);
        low0  = n_held_low;
        base2 = ev_code.size();
        key_mask = '0;
        repeat (4) @(negedge clk);
        key_mask[idx] = 1'b1;
        repeat (30) @(negedge clk);
        total_cnt++; if (n_held_low !== low0) $display("FAIL glitch_held_stays: got %0d low cycles expected 0", n_held_low - low0); else pass_cnt++;
        total_cnt++; if (ev_code.size() !== base2) $display("FAIL glitch_no_second_valid: got %0d events expected 0", ev_code.size() - base2); else pass_cnt++;
        key_mask = '0;
        wait_released(100, lat);
        total_cnt++; if (lat < 0) $display("FAIL glitch_release: got no release expected key_held low"); else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    // Asynchronous reset in the middle of press debounce, then fresh press.
    task automatic test_reset_mid_press();
        int base, lat, code, idx;
        bit got;
        idx  = 0*ROWS + 2;
        base = ev_code.size();
        key_mask[idx] = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (col_out !== '0) $display("FAIL midreset_col_out: got %b expected 0", col_out); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL midreset_key_valid: got %b expected 0", key_valid); else pass_cnt++;
        total_cnt++; if (key_held !== 1'b0) $display("FAIL midreset_key_held: got %b expected 0", key_held); else pass_cnt++;
        total_cnt++; if (ev_code.size() !== base) $display("FAIL midreset_no_early_valid: got %0d events expected 0", ev_code.size() - base); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_event(base, 200, got);
        repeat (5) @(negedge clk);
        code = got ? ev_code[base] : -1;
        total_cnt++; if (code !== idx) $display("FAIL after_reset_code: got %0d expected %0d", code, idx); else pass_cnt++;
        total_cnt++; if (ev_code.size() - base !== 1) $display("FAIL after_reset_count: got %0d expected 1", ev_code.size() - base); else pass_cnt++;
        key_mask = '0;
        wait_released(100, lat);
        repeat (5) @(negedge clk);
    endtask

    // Random single-key presses: code must equal col*ROWS + row.
    task automatic test_random_keys();
        int base, lat, code, c, r;
        bit got;
        for (int n = 0; n < 6; n++) begin
            c    = int'($urandom_range(COLS - 1));
            r    = int'($urandom_range(ROWS - 1));
            base = ev_code.size();
            key_mask[c*ROWS + r] = 1'b1;
            wait_event(base, 200, got);
            code = got ? ev_code[base] : -1;
            total_cnt++; if (code !== c*ROWS + r) $display("FAIL random_code[%0d]: got %0d expected %0d", n, code, c*ROWS + r); else pass_cnt++;
            repeat (5) @(negedge clk);
            key_mask = '0;
            wait_released(100, lat);
            total_cnt++; if (lat < 0) $display("FAIL random_release[%0d]: got no release expected key_held low", n); else pass_cnt++;
            total_cnt++; if (ev_code.size() - base !== 1) $display("FAIL random_count[%0d]: got %0d expected 1", n, ev_code.size() - base); else pass_cnt++;
            repeat (3) @(negedge clk);
        end
    endtask

    // Hold key 5 for 85 cycles past the press strobe.
    task automatic test_long_hold();
        int base, lat, t0, idx, nexp;
        bit got;
        int exp_off[$];
        idx  = 1*ROWS + 1;
        base = ev_code.size();
        key_mask[idx] = 1'b1;
        wait_event(base, 200, got);
        total_cnt++; if (got !== 1'b1) $display("FAIL hold_press_seen: got %b expected 1", got); else pass_cnt++;
        t0 = got ? ev_cyc[base] : 0;
        repeat (85) @(negedge clk);
        key_mask = '0;
        wait_released(100, lat);
        exp_off.push_back(0);
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int t = RPT_DELAY; t <= 80; t += RPT_PERIOD) exp_off.push_back(t);
`endif
        nexp = exp_off.size();
        total_cnt++; if (ev_code.size() - base !== nexp) $display("FAIL hold_event_count: got %0d expected %0d", ev_code.size() - base, nexp); else pass_cnt++;
        for (int k = 0; k < nexp; k++) begin
            if (base + k < ev_code.size()) begin
                total_cnt++; if (ev_code[base + k] !== idx) $display("FAIL hold_code[%0d]: got %0d expected %0d", k, ev_code[base + k], idx); else pass_cnt++;
                total_cnt++; if (ev_cyc[base + k] - t0 !== exp_off[k]) $display("FAIL hold_offset[%0d]: got %0d expected %0d", k, ev_cyc[base + k] - t0, exp_off[k]); else pass_cnt++;
            end
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_release_glitch();
        test_reset_mid_press();
        test_random_keys();
        test_long_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
